operand_mux_pipe: RTL and testbench

OPERAND_MUX_PIPE -- requirements
Module: operand_mux_pipe

---
 rtl/operand_mux_pipe_if.sv | 33 +++
 rtl/operand_mux_pipe.sv | 140 ++++++++++++++
 tb/tb_operand_mux_pipe.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/operand_mux_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : operand_mux_pipe_if
//  Description : Operand select/transfer bundle for operand_mux_pipe.
//  Revision    : 1.0 - initial release
// ============================================================================
interface operand_mux_pipe_if #(
    parameter int LEN_DATA = 16,
    parameter int NUM_SRC  = 4,
    parameter int LEN_SEL  = 2
);
    logic                         in_valid;
    logic                         in_ready;
    logic [LEN_SEL-1:0]           sel;
    logic [NUM_SRC*LEN_DATA-1:0]  src_data;
    logic                         clr_err;
    logic                         out_valid;
    logic                         out_ready;
    logic [LEN_DATA-1:0]          out;
    logic [LEN_SEL-1:0]           out_src;
    logic                         err_sel;

    modport master (
        output in_valid, sel, src_data, clr_err, out_ready,
        input  in_ready, out_valid, out, out_src, err_sel
    );

    modport slave (
        input  in_valid, sel, src_data, clr_err, out_ready,
        output in_ready, out_valid, out, out_src, err_sel
    );
endinterface
`default_nettype wire

// File: rtl/operand_mux_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : operand_mux_pipe
//  Description : Operand source mux feeding a two-entry skid buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module operand_mux_pipe #(
    parameter int LEN_DATA = 16,
    parameter int NUM_SRC  = 4,
    parameter int LEN_SEL  = 2
) (
    input  wire logic            clk,
    input  wire logic            reset,
    operand_mux_pipe_if.slave    bus
);
    localparam logic [1:0] c_st_empty = 2'd0;
    localparam logic [1:0] c_st_one   = 2'd1;
    localparam logic [1:0] c_st_full  = 2'd2;

    generate
        if ((2 ** LEN_SEL) < NUM_SRC || NUM_SRC < 2 || NUM_SRC > 16) begin : g_bad_params
            $error("operand_mux_pipe: invalid NUM_SRC/LEN_SEL combination");
        end
    endgenerate

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic                r_in_ready;
    logic                r_out_valid;
    logic [LEN_DATA-1:0] r_out;
    logic [LEN_SEL-1:0]  r_out_src;
    logic [LEN_DATA-1:0] r_skid_data;
    logic [LEN_SEL-1:0]  r_skid_src;
    logic                r_err_sel;
    logic [LEN_DATA-1:0] w_pick;
    logic                w_bad_sel;
    logic                w_push;
    logic                w_pop;
    logic                w_load_new;
    logic                w_load_skid;
    logic                w_fill_skid;

    // Out-of-range selects match no source and therefore yield zero data.
    always_comb begin
        w_pick    = '0;
        w_bad_sel = 1'b1;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (bus.sel == LEN_SEL'(k)) begin
                w_pick    = bus.src_data[k*LEN_DATA +: LEN_DATA];
                w_bad_sel = 1'b0;
            end
        end
    end

    assign w_push = bus.in_valid && r_in_ready;
    assign w_pop  = r_out_valid && bus.out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_load_new  = 1'b0;
        w_load_skid = 1'b0;
        w_fill_skid = 1'b0;
        case (r_state)
            c_st_empty: begin
                if (w_push) begin
                    w_state_nxt = c_st_one;
                    w_load_new  = 1'b1;
                end
            end
            c_st_one: begin
                if (w_push && w_pop) begin
                    w_load_new  = 1'b1;
                end else if (w_push) begin
                    w_state_nxt = c_st_full;
                    w_fill_skid = 1'b1;
                end else if (w_pop) begin
                    w_state_nxt = c_st_empty;
                end
            end
            c_st_full: begin
                if (w_pop) begin
                    w_state_nxt = c_st_one;
                    w_load_skid = 1'b1;
                end
            end
            default: w_state_nxt = c_st_empty;
        endcase
    end

    // Handshake outputs are registered from the next state so out_ready never reaches in_ready combinationally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= c_st_empty;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt != c_st_full);
            r_out_valid <= (w_state_nxt != c_st_empty);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out       <= '0;
            r_out_src   <= '0;
            r_skid_data <= '0;
            r_skid_src  <= '0;
        end else begin
            if (w_load_new) begin
                r_out     <= w_pick;
                r_out_src <= bus.sel;
            end else if (w_load_skid) begin
                r_out     <= r_skid_data;
                r_out_src <= r_skid_src;
            end
            if (w_fill_skid) begin
                r_skid_data <= w_pick;
                r_skid_src  <= bus.sel;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err_sel <= 1'b0;
        end else if (w_push && w_bad_sel) begin
            r_err_sel <= 1'b1;
        end else if (bus.clr_err) begin
            r_err_sel <= 1'b0;
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out       = r_out;
    assign bus.out_src   = r_out_src;
    assign bus.err_sel   = r_err_sel;
endmodule
`default_nettype wire

// File: tb/tb_operand_mux_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_operand_mux_pipe
//  Description : Scoreboard bench for operand_mux_pipe (4-source and 3-source).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_mux_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic armed;

    typedef struct {
        logic [1:0]  src;
        logic [15:0] data;
    } exp_t;

    exp_t        q[$];
    logic [15:0] last_out;
    logic [1:0]  last_src;
    logic [63:0] src4;
    logic [47:0] src3;
    logic [15:0] e_out3;
    logic [1:0]  e_src3;
    logic        e_err3;

    always #5 clk = ~clk;

    operand_mux_pipe_if #(.LEN_DATA(16), .NUM_SRC(4), .LEN_SEL(2)) m4 ();
    operand_mux_pipe_if #(.LEN_DATA(16), .NUM_SRC(3), .LEN_SEL(2)) m3 ();

    operand_mux_pipe #(.LEN_DATA(16), .NUM_SRC(4), .LEN_SEL(2)) dut4 (
        .clk   (clk),
        .reset (rst_n),
        .bus   (m4)
    );

    operand_mux_pipe #(.LEN_DATA(16), .NUM_SRC(3), .LEN_SEL(2)) dut3 (
        .clk   (clk),
        .reset (rst_n),
        .bus   (m3)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_pick(input int s, input logic [63:0] d, input int n);
        if (s >= n) return 16'h0;
        return 16'((d >> (16 * s)) & 64'hFFFF);
    endfunction

    // A transfer can only be accepted once a clock edge has been seen outside reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) armed <= 1'b0;
        else        armed <= 1'b1;
    end

    // Monitor: compares the 4-source DUT against the reference queue every cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_out_valid", m4.out_valid, 0);
            check("rst_in_ready", m4.in_ready, 0);
            check("rst_out", m4.out, 0);
            check("rst_out_src", m4.out_src, 0);
            check("rst_err_sel", m4.err_sel, 0);
            q.delete();
            last_out = 16'h0;
            last_src = 2'd0;
        end else begin
            check("out_valid", m4.out_valid, q.size() != 0);
            check("in_ready", m4.in_ready, armed && (q.size() < 2));
            check("err_sel4", m4.err_sel, 0);
            if (q.size() != 0) begin
                check("out", m4.out, q[0].data);
                check("out_src", m4.out_src, q[0].src);
                if (m4.out_ready) begin
                    last_out = q[0].data;
                    last_src = q[0].src;
                    void'(q.pop_front());
                end
            end else begin
                check("hold_out", m4.out, last_out);
                check("hold_src", m4.out_src, last_src);
            end
        end
    end

    task automatic step(input logic v, input logic [1:0] s, input logic [63:0] d, input logic ordy);
        exp_t e;
        @(posedge clk); #1;
        m4.in_valid  = v;
        m4.sel       = s;
        m4.src_data  = d;
        m4.out_ready = ordy;
        @(negedge clk); #1;
        if (v && m4.in_ready) begin
            e.src  = s;
            e.data = ref_pick(int'(s), d, 4);
            q.push_back(e);
        end
    endtask

    task automatic step3(input logic v, input logic [1:0] s, input logic clr);
        @(posedge clk); #1;
        m3.in_valid = v;
        m3.sel      = s;
        m3.clr_err  = clr;
        @(posedge clk); #1;
        m3.in_valid = 1'b0;
        m3.clr_err  = 1'b0;
        if (v) begin
            e_out3 = ref_pick(int'(s), {16'h0, src3}, 3);
            e_src3 = s;
        end
        if (v && (int'(s) >= 3)) e_err3 = 1'b1;
        else if (clr)            e_err3 = 1'b0;
        @(negedge clk);
        check("n3_out_valid", m3.out_valid, v);
        check("n3_out", m3.out, e_out3);
        check("n3_out_src", m3.out_src, e_src3);
        check("n3_err_sel", m3.err_sel, e_err3);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        src4 = 64'h4444_3333_2222_1111;
        src3 = 48'h3333_2222_1111;
        e_out3 = 16'h0;
        e_src3 = 2'd0;
        e_err3 = 1'b0;
        m4.in_valid = 1'b0; m4.sel = 2'd0; m4.src_data = '0; m4.clr_err = 1'b0; m4.out_ready = 1'b0;
        m3.in_valid = 1'b0; m3.sel = 2'd0; m3.src_data = src3; m3.clr_err = 1'b0; m3.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        step(0, 0, src4, 1);

        // Single transfer, one-cycle latency.
        step(1, 2, src4, 1);
        step(0, 0, src4, 1);
        step(0, 0, src4, 1);

        // Fill under back-pressure, in_valid ignored while full, then drain.
        step(1, 0, src4, 0);
        step(1, 1, src4, 0);
        step(0, 0, src4, 0);
        step(1, 3, src4, 0);
        step(0, 0, src4, 1);
        step(0, 0, src4, 1);
        step(0, 0, src4, 1);

        // Back-to-back stream.
        for (int i = 0; i < 4; i++) step(1, 2'(i), src4, 1);
        step(0, 0, src4, 1);
        step(0, 0, src4, 1);

        // Asynchronous reset while full.
        step(1, 2, src4, 0);
        step(1, 3, src4, 0);
        step(0, 0, src4, 0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", m4.out_valid, 0);
        check("async_rst_in_ready", m4.in_ready, 0);
        q.delete();
        m4.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step(1, 1, src4, 0);
        step(1, 2, src4, 0);
        step(0, 0, src4, 1);
        step(0, 0, src4, 1);
        step(0, 0, src4, 1);

        // Randomized traffic.
        for (int i = 0; i < 10000; i++) begin
            step(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                 {$urandom, $urandom}, 1'($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 6 && q.size() != 0; i++) step(0, 0, src4, 1);
        check("drain_empty", q.size(), 0);

        // Select-range error handling on the 3-source instance.
        step3(1, 3, 0);
        step3(0, 0, 1);
        step3(1, 3, 1);
        step3(1, 1, 0);
        step3(1, 2, 1);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
